// File: rtl/shake_arbiter_if.sv
// rtl/shake_arbiter_if.sv - requester-side and SHAKE-core-side handshake bundle for shake_arbiter
interface shake_arbiter_if #(
  parameter int W       = 64,
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid_in;
  logic [NUM_REQ*W-1:0] req_data_in;
  logic [NUM_REQ-1:0]   req_ready_out;
  logic [NUM_REQ-1:0]   req_valid_out;
  logic [W-1:0]         req_data_out;
  logic [NUM_REQ-1:0]   req_ready_in;

  logic                 core_valid_in;
  logic [W-1:0]         core_data_in;
  logic                 core_ready_out;
  logic                 core_valid_out;
  logic [W-1:0]         core_data_out;
  logic                 core_ready_in;

  // Arbiter view: consumes requester words and core digests, drives the rest.
  modport slave (
    input  req_valid_in,
    input  req_data_in,
    output req_ready_out,
    output req_valid_out,
    output req_data_out,
    input  req_ready_in,
    output core_valid_in,
    output core_data_in,
    input  core_ready_out,
    input  core_valid_out,
    input  core_data_out,
    output core_ready_in
  );

  modport master (
    output req_valid_in,
    output req_data_in,
    input  req_ready_out,
    input  req_valid_out,
    input  req_data_out,
    output req_ready_in,
    input  core_valid_in,
    input  core_data_in,
    output core_ready_out,
    output core_valid_out,
    output core_data_out,
    input  core_ready_in
  );
endinterface

// File: rtl/shake_arbiter.sv
// rtl/shake_arbiter.sv - round-robin arbiter sharing one SHAKE core among NUM_REQ requesters
module shake_arbiter #(
  parameter int W       = 64,
  parameter int NUM_REQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  shake_arbiter_if.slave  bus,
  output logic [1:0]      grant_idx,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    ABSORB  = 2'd2,
    SQUEEZE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  rr_q, rr_d;
  logic [28:0] in_cnt_q, in_cnt_d;
  logic [29:0] out_cnt_q, out_cnt_d;
  logic        armed_q;

  logic         own_valid;
  logic         own_ready_in;
  logic [W-1:0] own_word;

  logic         win_found;
  logic [1:0]   win_idx;
  logic [1:0]   rr_next;
  logic         msg_done;

  logic [28:0]  in_w;
  logic [29:0]  out_w;

  logic [NUM_REQ-1:0] ready_vec;
  logic [NUM_REQ-1:0] valid_vec;
  logic [W-1:0]       dig_word;
  logic               fwd_valid;
  logic [W-1:0]       fwd_word;
  logic               dig_accept;
  logic               xfer_in;
  logic               xfer_out;

  // Owner-side view of the requester bundle.
  always_comb begin
    own_valid    = 1'b0;
    own_ready_in = 1'b0;
    own_word     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 2'(i)) begin
        own_valid    = bus.req_valid_in[i];
        own_ready_in = bus.req_ready_in[i];
        own_word     = bus.req_data_in[i*W +: W];
      end
    end
  end

  // First valid requester at or after rr_q, scanning in rotation order.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!win_found && bus.req_valid_in[j] &&
            (j == ((int'(rr_q) + k) % NUM_REQ))) begin
          win_found = 1'b1;
          win_idx   = 2'(j);
        end
      end
    end
  end

  // Byte lengths rounded up to 64-bit words; widths chosen so the +1 cannot wrap.
  assign in_w  = {3'b000, own_word[60:35]} + {28'd0, |own_word[34:32]};
  assign out_w = {1'b0, own_word[31:3]}   + {29'd0, |own_word[2:0]};

  assign rr_next = (grant_q == 2'(NUM_REQ - 1)) ? 2'd0 : grant_q + 2'd1;

  always_comb begin
    ready_vec  = '0;
    valid_vec  = '0;
    dig_word   = '0;
    fwd_valid  = 1'b0;
    fwd_word   = '0;
    dig_accept = 1'b0;
    case (state_q)
      HEADER, ABSORB: begin
        fwd_valid = own_valid;
        fwd_word  = own_valid ? own_word : '0;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_q == 2'(i)) ready_vec[i] = bus.core_ready_out;
        end
      end
      SQUEEZE: begin
        dig_accept = own_ready_in;
        dig_word   = bus.core_data_out;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_q == 2'(i)) valid_vec[i] = bus.core_valid_out;
        end
      end
      default: ;
    endcase
  end

  assign xfer_in  = fwd_valid && bus.core_ready_out;
  assign xfer_out = bus.core_valid_out && dig_accept;

  assign bus.req_ready_out = ready_vec;
  assign bus.req_valid_out = valid_vec;
  assign bus.req_data_out  = dig_word;
  assign bus.core_valid_in = fwd_valid;
  assign bus.core_data_in  = fwd_word;
  assign bus.core_ready_in = dig_accept;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    msg_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q && win_found) begin
          state_d = HEADER;
          grant_d = win_idx;
        end
      end
      HEADER: begin
        if (xfer_in) begin
          in_cnt_d  = in_w;
          out_cnt_d = out_w;
          if (in_w != '0)       state_d  = ABSORB;
          else if (out_w != '0) state_d  = SQUEEZE;
          else                  msg_done = 1'b1;
        end
      end
      ABSORB: begin
        if (xfer_in) begin
          in_cnt_d = in_cnt_q - 29'd1;
          if (in_cnt_q == 29'd1) begin
            if (out_cnt_q != '0) state_d  = SQUEEZE;
            else                 msg_done = 1'b1;
          end
        end
      end
      SQUEEZE: begin
        if (xfer_out) begin
          out_cnt_d = out_cnt_q - 30'd1;
          if (out_cnt_q == 30'd1) msg_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (msg_done) begin
      state_d = IDLE;
      rr_d    = rr_next;
    end
  end

  // armed_q holds off the first grant until one full clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'd0;
      rr_q      <= 2'd0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      armed_q   <= 1'b1;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shake_arbiter.sv
// tb/tb_shake_arbiter.sv - scoreboard bench for shake_arbiter with a queue-driven SHAKE core model
module tb_shake_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] grant_idx;
  logic       busy;

  shake_arbiter_if #(.W(64), .NUM_REQ(2)) bus ();

  shake_arbiter #(.W(64), .NUM_REQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] co_q[$];
  logic [63:0] exp_ci_w[$];
  int          exp_ci_o[$];
  logic [63:0] exp_dg_w[$];
  int          exp_dg_o[$];

  logic [1:0] f_rq = 2'b00;
  logic       f_dg = 1'b0;
  logic       bp_en = 1'b0;
  logic       stall_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #2;
  endtask

  task automatic send_msg(input int who, input logic [28:0] in_b, input logic [31:0] out_b,
                          input int in_w, input int out_w, input logic [7:0] tag);
    logic [63:0] w;
    w = {3'd5, in_b, out_b};
    if (who == 0) q0.push_back(w); else q1.push_back(w);
    exp_ci_w.push_back(w);
    exp_ci_o.push_back(who);
    for (int k = 0; k < in_w; k++) begin
      w = {8'hA5, tag, 16'h0000, 32'(k)};
      if (who == 0) q0.push_back(w); else q1.push_back(w);
      exp_ci_w.push_back(w);
      exp_ci_o.push_back(who);
    end
    for (int k = 0; k < out_w; k++) begin
      w = {8'hD1, tag, 16'hFFFF, 32'(k)};
      co_q.push_back(w);
      exp_dg_w.push_back(w);
      exp_dg_o.push_back(who);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_ci_w.size() != 0 || exp_dg_w.size() != 0 || q0.size() != 0 ||
            q1.size() != 0 || co_q.size() != 0 || busy) && n < 3000) begin
      wait_neg();
      n++;
    end
    n_cmp++;
    if (n >= 3000) begin
      n_err++;
      $display("FAIL %s_drain: %0d core-in and %0d digest words pending, expected 0",
               nm, exp_ci_w.size(), exp_dg_w.size());
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"},      64'(busy), 64'd0);
    chk({nm, "_grant"},     64'(grant_idx), 64'd0);
    chk({nm, "_cvalid"},    64'(bus.core_valid_in), 64'd0);
    chk({nm, "_cdata"},     bus.core_data_in, 64'd0);
    chk({nm, "_cready"},    64'(bus.core_ready_in), 64'd0);
    chk({nm, "_rready"},    64'(bus.req_ready_out), 64'd0);
    chk({nm, "_rvalid"},    64'(bus.req_valid_out), 64'd0);
    chk({nm, "_rdata"},     bus.req_data_out, 64'd0);
  endtask

  // Requester drivers and SHAKE core model; they only advance on handshakes seen by the monitor.
  always @(posedge clk) begin
    #1;
    if (f_rq[0] && q0.size() != 0) void'(q0.pop_front());
    if (f_rq[1] && q1.size() != 0) void'(q1.pop_front());
    if (f_dg && co_q.size() != 0) void'(co_q.pop_front());
    bus.req_valid_in[0] = (q0.size() != 0) && (!stall_en || $urandom_range(0, 3) != 0);
    bus.req_valid_in[1] = (q1.size() != 0) && (!stall_en || $urandom_range(0, 3) != 0);
    bus.req_data_in[63:0]   = (q0.size() != 0) ? q0[0] : 64'd0;
    bus.req_data_in[127:64] = (q1.size() != 0) ? q1[0] : 64'd0;
    bus.req_ready_in   = bp_en ? 2'($urandom_range(0, 3)) : 2'b11;
    bus.core_ready_out = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.core_valid_out = (co_q.size() != 0) && (!bp_en || $urandom_range(0, 1) != 0);
    bus.core_data_out  = (co_q.size() != 0) ? co_q[0] : 64'd0;
  end

  // Monitor: pops expected words on every handshake and checks owner isolation each cycle.
  always @(negedge clk) begin
    logic [1:0] rmask;
    logic [1:0] vmask;
    f_rq = 2'b00;
    f_dg = 1'b0;
    if (rst) begin
      rmask = (exp_ci_o.size() != 0) ? (2'b01 << exp_ci_o[0]) : 2'b00;
      vmask = (exp_dg_o.size() != 0) ? (2'b01 << exp_dg_o[0]) : 2'b00;
      chk("ready_isolation", 64'(bus.req_ready_out & ~rmask), 64'd0);
      chk("valid_isolation", 64'(bus.req_valid_out & ~vmask), 64'd0);
      if (!bus.core_valid_in) chk("core_data_idle", bus.core_data_in, 64'd0);
      if (bus.core_valid_in && bus.core_ready_out) begin
        if (exp_ci_w.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL core_in_extra: got %h, expected no transfer", bus.core_data_in);
        end else begin
          chk("core_in_word", bus.core_data_in, exp_ci_w[0]);
          chk("core_in_owner", 64'(grant_idx), 64'(exp_ci_o[0]));
          void'(exp_ci_w.pop_front());
          void'(exp_ci_o.pop_front());
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid_out[i] && bus.req_ready_in[i]) begin
          if (exp_dg_w.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL digest_extra: got %h to req %0d, expected no transfer",
                     bus.req_data_out, i);
          end else begin
            chk("digest_word", bus.req_data_out, exp_dg_w[0]);
            chk("digest_owner", 64'(i), 64'(exp_dg_o[0]));
            void'(exp_dg_w.pop_front());
            void'(exp_dg_o.pop_front());
          end
        end
      end
      f_rq = bus.req_valid_in & bus.req_ready_out;
      f_dg = bus.core_valid_out & bus.core_ready_in;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid_in   = '0;
    bus.req_data_in    = '0;
    bus.req_ready_in   = '0;
    bus.core_ready_out = 1'b0;
    bus.core_valid_out = 1'b0;
    bus.core_data_out  = '0;

    repeat (3) @(posedge clk);
    wait_neg();
    chk_all_zero("reset");

    // Single message queued before reset release: grant no earlier than the second edge.
    send_msg(0, 29'd17, 32'd32, 3, 4, 8'h01);
    @(negedge clk);
    rst = 1'b1;
    wait_neg();
    chk("first_grant_edge1_busy", 64'(busy), 64'd0);
    wait_neg();
    chk("first_grant_edge2_busy", 64'(busy), 64'd1);
    n = 0;
    while (exp_dg_w.size() != 0 && n < 500) begin wait_neg(); n++; end
    chk("last_digest_busy_high", 64'(busy), 64'd1);
    wait_neg();
    chk("busy_fall_after_last", 64'(busy), 64'd0);
    drain("single");

    // rr_ptr now 1: simultaneous requests go to requester 1 first.
    send_msg(1, 29'd8, 32'd8, 1, 1, 8'h02);
    send_msg(0, 29'd8, 32'd8, 1, 1, 8'h03);
    drain("rr_after_single");

    // Contention from reset: grants alternate 0,1,0,1; the idle requester stays isolated.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    send_msg(0, 29'd9,  32'd16, 2, 2, 8'h10);
    send_msg(1, 29'd24, 32'd7,  3, 1, 8'h11);
    send_msg(0, 29'd1,  32'd8,  1, 1, 8'h12);
    send_msg(1, 29'd16, 32'd17, 2, 3, 8'h13);
    drain("contention");

    // Zero lengths: header straight to squeeze, and header-only release.
    send_msg(0, 29'd0, 32'd64, 0, 8, 8'h20);
    send_msg(1, 29'd0, 32'd0,  0, 0, 8'h21);
    drain("zero_len");

    // Backpressure on both core sides plus requester valid stalls.
    bp_en    = 1'b1;
    stall_en = 1'b1;
    send_msg(1, 29'd23, 32'd20, 3, 3, 8'h30);
    drain("bp_a");
    send_msg(0, 29'd64, 32'd1, 8, 1, 8'h31);
    drain("bp_b");
    send_msg(0, 29'd5, 32'd0, 1, 0, 8'h32);
    drain("bp_c");
    bp_en    = 1'b0;
    stall_en = 1'b0;
    wait_neg();

    // Reset mid-absorb after header and 2 of 5 words.
    send_msg(0, 29'd40, 32'd8, 5, 1, 8'h40);
    n = 0;
    while (exp_ci_w.size() > 3 && n < 500) begin wait_neg(); n++; end
    chk("mid_reset_progress", 64'(exp_ci_w.size()), 64'd3);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    q0.delete();
    q1.delete();
    co_q.delete();
    exp_ci_w.delete();
    exp_ci_o.delete();
    exp_dg_w.delete();
    exp_dg_o.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    send_msg(1, 29'd16, 32'd16, 2, 2, 8'h50);
    drain("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shake_arbiter.md
SHAKE_ARBITER -- requirements
Module: shake_arbiter

Interface
REQ-001 Parameter W, default 64: data word width in bits; the only supported value is 64.
REQ-002 Parameter NUM_REQ, default 2: number of requesters; legal range 2..4.
REQ-003 Port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid_in  input  NUM_REQ  per-requester input word valid.
REQ-006 Port req_data_in  input  NUM_REQ*W  per-requester input word; requester i occupies bits [i*W +: W].
REQ-007 Port req_ready_out  output  NUM_REQ  per-requester input accept.
REQ-008 Port req_valid_out  output  NUM_REQ  per-requester digest word valid.
REQ-009 Port req_data_out  output  W  digest word, broadcast to all requesters.
REQ-010 Port req_ready_in  input  NUM_REQ  per-requester digest accept.
REQ-011 Port core_valid_in, core_data_in[W]  output  SHAKE core input stream.
REQ-012 Port core_ready_out  input  1  SHAKE core input accept.
REQ-013 Port core_valid_out, core_data_out[W]  input  SHAKE core digest stream.
REQ-014 Port core_ready_in  output  1  digest accept to the core.
REQ-015 Port grant_idx  output  2  current owner; busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-016 A word SHALL transfer on any edge where the matching valid and ready are both high.
REQ-017 Header word fields: [63:61] mode, [60:32] input length in bytes (IN_B), [31:0] output length in bytes (OUT_B).
REQ-018 The arbiter SHALL forward the header to the core unmodified.
REQ-019 Word counts: IN_W = ceil(IN_B/8) and OUT_W = ceil(OUT_B/8), computed without overflow at 29 and 30 bits.
REQ-020 FSM states SHALL be IDLE, HEADER, ABSORB and SQUEEZE.
REQ-021 IDLE: when any req_valid_in is high, grant the round-robin winner (first requester at or after rr_ptr), latch it into grant_idx and go to HEADER; the grant takes one cycle and no transfer occurs in IDLE.
REQ-022 HEADER: connect the owner to core input combinationally (zero latency).
REQ-023 On the HEADER transfer, load in_cnt=IN_W and out_cnt=OUT_W.
REQ-024 HEADER exit: go to ABSORB if IN_W>0; else SQUEEZE if OUT_W>0; else release.
REQ-025 ABSORB: pass the owner's words through and decrement in_cnt on each transfer.
REQ-026 ABSORB exit: on the transfer that makes in_cnt 0, go to SQUEEZE, or release if OUT_W=0.
REQ-027 SQUEEZE: req_valid_out[owner]=core_valid_out, core_ready_in=req_ready_in[owner], req_data_out=core_data_out.
REQ-028 SQUEEZE: decrement out_cnt on each transfer; on the last transfer, release.
REQ-029 Release: return to IDLE and set rr_ptr=(owner+1) mod NUM_REQ; no new grant is made in the same cycle.
REQ-030 Non-owners SHALL see req_ready_out=0 and req_valid_out=0 at all times.
REQ-031 Outside SQUEEZE: core_ready_in=0 and all req_valid_out=0.
REQ-032 Outside HEADER/ABSORB: core_valid_in=0 and all req_ready_out=0.
REQ-033 core_data_in SHALL equal the owner's word when core_valid_in=1; otherwise it is 0.
REQ-034 A requester dropping valid mid-message SHALL stall the FSM; the grant is never revoked.
REQ-035 Simultaneous requests: the winner is decided by rr_ptr only; a losing requester SHALL be granted within NUM_REQ-1 further messages.

Reset
REQ-036 While rst=0, asynchronously force: FSM=IDLE, rr_ptr=0, grant_idx=0, in_cnt=0, out_cnt=0, busy=0, all ready and valid outputs 0, and all data outputs 0.
REQ-037 Reset asserted mid-message SHALL abandon the message with no further transfers; the SHAKE core is reset by the same rst.
REQ-038 After rst rises, the first grant SHALL occur no earlier than the second rising edge.

Verification
REQ-039 Single message: requester 0, IN_B=17, OUT_B=32 -> 1 header, 3 input and 4 output words pass through; busy falls the cycle after the 4th output; rr_ptr=1.
REQ-040 Contention: both requesters valid in the same cycle after reset -> req0 served first, then req1; with both continuously valid, grants alternate 0,1,0,1.
REQ-041 Zero lengths: IN_B=0, OUT_B=64 -> HEADER then SQUEEZE with 8 outputs; IN_B=0, OUT_B=0 -> release right after the header.
REQ-042 Backpressure: random toggling of core_ready_out and req_ready_in -> no word lost or duplicated, and counts equal IN_W/OUT_W exactly.
REQ-043 Isolation: non-owner valid high throughout a message -> its req_ready_out stays 0 and its req_valid_out stays 0.
REQ-044 Reset mid-ABSORB (2 of 5 words sent) -> all outputs 0 immediately; a fresh message after reset completes normally.
